// File: rtl/rle_pixel_sequencer.sv
// Run-length pixel sequencer: prefetches 18-bit {colour, run} instructions from the flash
// reader into a small FIFO and expands them into one RGB222 pixel per display request.
module rle_pixel_sequencer #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned GUARD = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] instr,
  input  logic        instr_valid,
  output logic        shift_data,
  input  logic        pixel_req,
  output logic [5:0]  rgb_out,
  output logic        pixel_valid,
  output logic        underrun,
  input  logic        underrun_clr,
  output logic [2:0]  fifo_count
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned GcntW = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [2:0]  DepthCnt = 3'(DEPTH);
  localparam logic [GcntW-1:0] GuardLast = GcntW'(GUARD - 1);

  typedef enum logic [0:0] {StWait, StGuard} fetch_state_e;

  fetch_state_e     state_q, state_d;
  logic [GcntW-1:0] guard_cnt_q, guard_cnt_d;
  logic             shift_data_q, shift_data_d;

  logic [17:0]      mem_q [DEPTH];
  logic [17:0]      mem_d [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]       count_q, count_d;

  logic             loaded_q, loaded_d;
  logic [11:0]      run_left_q, run_left_d;
  logic [5:0]       colour_q, colour_d;
  logic [5:0]       rgb_q, rgb_d;
  logic             pixel_valid_q, pixel_valid_d;
  logic             underrun_q, underrun_d;

  logic             push, pop, full, empty, underrun_set;
  logic [17:0]      head;

  // Full check uses the pre-pop count, so a push never races a pop out of a full FIFO.
  assign full  = (count_q == DepthCnt);
  assign empty = (count_q == 3'd0);
  assign head  = mem_q[rd_ptr_q];

  // Fetch FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StWait;
      guard_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      guard_cnt_q <= guard_cnt_d;
    end
  end

  // Fetch FSM: next state
  always_comb begin
    state_d     = state_q;
    guard_cnt_d = guard_cnt_q;
    case (state_q)
      StWait: begin
        if (instr_valid && !full) begin
          state_d     = StGuard;
          guard_cnt_d = '0;
        end
      end
      StGuard: begin
        if (guard_cnt_q == GuardLast) begin
          state_d = StWait;
        end else begin
          guard_cnt_d = guard_cnt_q + 1'b1;
        end
      end
      default: state_d = StWait;
    endcase
  end

  // Fetch FSM: outputs
  always_comb begin
    push         = (state_q == StWait) && instr_valid && !full;
    shift_data_d = push;
  end

  // FIFO next state
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = instr;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + {2'b00, push} - {2'b00, pop};
  end

  // Pixel path: an unloaded run pops the head and emits its first pixel in the same cycle.
  always_comb begin
    loaded_d      = loaded_q;
    run_left_d    = run_left_q;
    colour_d      = colour_q;
    rgb_d         = rgb_q;
    pixel_valid_d = 1'b0;
    pop           = 1'b0;
    underrun_set  = 1'b0;
    if (pixel_req) begin
      pixel_valid_d = 1'b1;
      if (loaded_q) begin
        rgb_d = colour_q;
        if (run_left_q != 12'd0) begin
          run_left_d = run_left_q - 12'd1;
        end
        if (run_left_q == 12'd1) begin
          loaded_d = 1'b0;
        end
      end else if (!empty) begin
        pop        = 1'b1;
        colour_d   = head[17:12];
        rgb_d      = head[17:12];
        run_left_d = head[11:0];
        loaded_d   = (head[11:0] != 12'd0);
      end else begin
        rgb_d        = 6'd0;
        underrun_set = 1'b1;
      end
    end
    underrun_d = underrun_set | (underrun_q & ~underrun_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_data_q  <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= 3'd0;
      loaded_q      <= 1'b0;
      run_left_q    <= 12'd0;
      colour_q      <= 6'd0;
      rgb_q         <= 6'd0;
      pixel_valid_q <= 1'b0;
      underrun_q    <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= 18'd0;
      end
    end else begin
      shift_data_q  <= shift_data_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      loaded_q      <= loaded_d;
      run_left_q    <= run_left_d;
      colour_q      <= colour_d;
      rgb_q         <= rgb_d;
      pixel_valid_q <= pixel_valid_d;
      underrun_q    <= underrun_d;
      mem_q         <= mem_d;
    end
  end

  assign shift_data  = shift_data_q;
  assign rgb_out     = rgb_q;
  assign pixel_valid = pixel_valid_q;
  assign underrun    = underrun_q;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_rle_pixel_sequencer.sv
// Self-checking bench for rle_pixel_sequencer: a flash-reader model feeds instructions and a
// scoreboard of expected pixels is drained as the DUT emits them.
module tb_rle_pixel_sequencer;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned GUARD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] instr = 18'd0;
  logic        instr_valid = 1'b0;
  logic        shift_data;
  logic        pixel_req = 1'b0;
  logic [5:0]  rgb_out;
  logic        pixel_valid;
  logic        underrun;
  logic        underrun_clr = 1'b0;
  logic [2:0]  fifo_count;

  typedef struct {
    logic [5:0] c;
    bit         first;
  } px_t;

  logic [17:0] src[$];
  px_t         exp_q[$];
  int          push_cnt = 0;
  int          push_base = 0;
  int          checks = 0;
  int          passed = 0;

  rle_pixel_sequencer #(.DEPTH(DEPTH), .GUARD(GUARD)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .shift_data  (shift_data),
    .pixel_req   (pixel_req),
    .rgb_out     (rgb_out),
    .pixel_valid (pixel_valid),
    .underrun    (underrun),
    .underrun_clr(underrun_clr),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  // Flash reader model: presents the head of src, advances on each consume pulse.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (shift_data === 1'b1) begin
        push_cnt++;
        if (src.size() > 0) void'(src.pop_front());
      end
      instr_valid = (src.size() > 0);
      instr       = (src.size() > 0) ? src[0] : 18'd0;
    end
  end

  task automatic push_instr(input logic [5:0] col, input logic [11:0] run);
    src.push_back({col, run});
    for (int i = 0; i <= int'(run); i++) exp_q.push_back('{c: col, first: (i == 0)});
  endtask

  task automatic do_reset();
    pixel_req    = 1'b0;
    underrun_clr = 1'b0;
    rst          = 1'b1;
    src.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst       = 1'b0;
    push_base = push_cnt;
  endtask

  task automatic test_reset();
    int pulses;
    rst = 1'b1;
    #3;
    checks++; if (rgb_out !== 6'd0) $display("FAIL reset_rgb: got %h want 00", rgb_out); else passed++;
    checks++; if (pixel_valid !== 1'b0) $display("FAIL reset_pv: got %b want 0", pixel_valid); else passed++;
    checks++; if (underrun !== 1'b0) $display("FAIL reset_underrun: got %b want 0", underrun); else passed++;
    checks++; if (fifo_count !== 3'd0) $display("FAIL reset_count: got %0d want 0", fifo_count); else passed++;
    checks++; if (shift_data !== 1'b0) $display("FAIL reset_shift: got %b want 0", shift_data); else passed++;
    do_reset();
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #2;
      if (shift_data === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) $display("FAIL idle_shift: got %0d pulses want 0", pulses); else passed++;
    checks++; if (fifo_count !== 3'd0) $display("FAIL idle_count: got %0d want 0", fifo_count); else passed++;
  endtask

  task automatic test_prefetch();
    int pulse_at[$];
    px_t px;
    do_reset();
    push_instr(6'h01, 12'd3);
    push_instr(6'h02, 12'd3);
    push_instr(6'h03, 12'd3);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #2;
      if (shift_data === 1'b1) pulse_at.push_back(i);
    end
    checks++;
    if (pulse_at.size() != int'(DEPTH))
      $display("FAIL prefetch_pulses: got %0d want %0d", pulse_at.size(), DEPTH);
    else passed++;
    if (pulse_at.size() >= 2) begin
      checks++;
      if (pulse_at[1] - pulse_at[0] != int'(GUARD) + 1)
        $display("FAIL prefetch_spacing: got %0d want %0d", pulse_at[1] - pulse_at[0], GUARD + 1);
      else passed++;
    end
    checks++;
    if (fifo_count !== 3'(DEPTH)) $display("FAIL prefetch_count: got %0d want %0d", fifo_count, DEPTH);
    else passed++;
    pixel_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() == 0) $display("FAIL prefetch_drain: got pixel %h want none", rgb_out);
      else begin
        px = exp_q.pop_front();
        if (pixel_valid !== 1'b1 || rgb_out !== px.c)
          $display("FAIL prefetch_pixel%0d: got %b/%h want 1/%h", i, pixel_valid, rgb_out, px.c);
        else passed++;
      end
    end
    pixel_req = 1'b0;
    checks++; if (underrun !== 1'b0) $display("FAIL prefetch_underrun: got %b want 0", underrun); else passed++;
  endtask

  task automatic test_runs();
    bit ok;
    px_t px;
    do_reset();
    push_instr(6'h30, 12'd2);
    push_instr(6'h0C, 12'd0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #2;
      if (fifo_count == 3'd2) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) $display("FAIL runs_fill: got count %0d want 2", fifo_count); else passed++;
    checks++; if (pixel_valid !== 1'b0) $display("FAIL runs_pv_idle: got %b want 0", pixel_valid); else passed++;
    pixel_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #2;
      if (i == 3) pixel_req = 1'b0;
      checks++;
      if (exp_q.size() == 0) $display("FAIL runs_drain: got pixel %h want none", rgb_out);
      else begin
        px = exp_q.pop_front();
        if (pixel_valid !== 1'b1 || rgb_out !== px.c)
          $display("FAIL runs_pixel%0d: got %b/%h want 1/%h", i, pixel_valid, rgb_out, px.c);
        else passed++;
      end
    end
    @(posedge clk);
    #2;
    checks++; if (pixel_valid !== 1'b0) $display("FAIL runs_pv_drop: got %b want 0", pixel_valid); else passed++;
    checks++; if (rgb_out !== 6'h0C) $display("FAIL runs_hold: got %h want 0c", rgb_out); else passed++;
  endtask

  task automatic test_underrun();
    do_reset();
    pixel_req = 1'b1;
    @(posedge clk);
    #2;
    pixel_req = 1'b0;
    checks++;
    if (rgb_out !== 6'd0 || pixel_valid !== 1'b1 || underrun !== 1'b1)
      $display("FAIL underrun_set: got %h/%b/%b want 00/1/1", rgb_out, pixel_valid, underrun);
    else passed++;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (underrun !== 1'b1) $display("FAIL underrun_sticky: got %b want 1", underrun); else passed++;
    underrun_clr = 1'b1;
    @(posedge clk);
    #2;
    underrun_clr = 1'b0;
    checks++; if (underrun !== 1'b0) $display("FAIL underrun_clear: got %b want 0", underrun); else passed++;
    underrun_clr = 1'b1;
    pixel_req    = 1'b1;
    @(posedge clk);
    #2;
    underrun_clr = 1'b0;
    pixel_req    = 1'b0;
    checks++; if (underrun !== 1'b1) $display("FAIL underrun_setwins: got %b want 1", underrun); else passed++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int pops, sim, model;
    logic [2:0] prev;
    px_t px;
    do_reset();
    push_instr(6'h11, 12'd1);
    push_instr(6'h22, 12'd1);
    push_instr(6'h33, 12'd1);
    push_instr(6'h04, 12'd1);
    push_instr(6'h05, 12'd1);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #2;
      if (fifo_count == 3'(DEPTH)) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) $display("FAIL b2b_fill: got count %0d want %0d", fifo_count, DEPTH); else passed++;
    repeat (4) @(posedge clk);
    #2;
    pops = 0;
    sim  = 0;
    prev = fifo_count;
    pixel_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL b2b_drain: got pixel %h want none", rgb_out);
      end else begin
        px = exp_q.pop_front();
        if (px.first) pops++;
        if (pixel_valid !== 1'b1 || rgb_out !== px.c)
          $display("FAIL b2b_pixel%0d: got %b/%h want 1/%h", i, pixel_valid, rgb_out, px.c);
        else passed++;
        if (shift_data === 1'b1 && px.first && fifo_count == prev) sim++;
      end
      model = push_cnt - push_base - pops;
      checks++;
      if (int'(fifo_count) != model) $display("FAIL b2b_count%0d: got %0d want %0d", i, fifo_count, model);
      else passed++;
      prev = fifo_count;
    end
    pixel_req = 1'b0;
    checks++; if (sim < 1) $display("FAIL b2b_simultaneous: got %0d events want >=1", sim); else passed++;
    checks++; if (underrun !== 1'b0) $display("FAIL b2b_underrun: got %b want 0", underrun); else passed++;
  endtask

  task automatic test_async_reset();
    bit ok;
    px_t px;
    do_reset();
    push_instr(6'h2A, 12'd99);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #2;
      if (fifo_count == 3'd1) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) $display("FAIL arst_fill: got count %0d want 1", fifo_count); else passed++;
    pixel_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #2;
      px = exp_q.pop_front();
      checks++;
      if (pixel_valid !== 1'b1 || rgb_out !== px.c)
        $display("FAIL arst_pixel%0d: got %b/%h want 1/%h", i, pixel_valid, rgb_out, px.c);
      else passed++;
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (rgb_out !== 6'd0 || pixel_valid !== 1'b0 || fifo_count !== 3'd0)
      $display("FAIL arst_clear: got %h/%b/%0d want 00/0/0", rgb_out, pixel_valid, fifo_count);
    else passed++;
    pixel_req = 1'b0;
    src.delete();
    exp_q.delete();
    push_instr(6'h15, 12'd1);
    @(posedge clk);
    #2;
    rst       = 1'b0;
    push_base = push_cnt;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #2;
      if (fifo_count == 3'd1) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) $display("FAIL arst_refetch: got count %0d want 1", fifo_count); else passed++;
    pixel_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #2;
      px = exp_q.pop_front();
      checks++;
      if (pixel_valid !== 1'b1 || rgb_out !== px.c)
        $display("FAIL arst_fresh%0d: got %b/%h want 1/%h", i, pixel_valid, rgb_out, px.c);
      else passed++;
    end
    pixel_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_prefetch();
    test_runs();
    test_underrun();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
